snn_step_scheduler: RTL and testbench

Timestep scheduler for the spiking network. It collects spike events from the input neurons, then shares the single synapse-accumulate datapath among them. Events are serialized one at a time over a valid/ready handshake in round-robin order. After each event burst it sequences the network's leak and fire phases. It sits between the input neuron pins and the spiking network core inside the Tiny Tapeout wrapper.

---
 rtl/snn_step_scheduler_if.sv | 39 +++
 rtl/snn_step_scheduler.sv | 117 +++++++++++
 tb/tb_snn_step_scheduler.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/snn_step_scheduler_if.sv
// Event/phase bus between the timestep scheduler and the spiking network core.
interface snn_step_scheduler_if #(
  parameter int unsigned N_IN = 3
);
  localparam int unsigned IDW = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic [N_IN-1:0] spike_in;
  logic            evt_valid;
  logic [IDW-1:0]  evt_id;
  logic            evt_ready;
  logic            leak_en;
  logic            fire_en;
  logic [7:0]      step_idx;
  logic            overrun;

  // Scheduler side
  modport master (
    input  spike_in,
    input  evt_ready,
    output evt_valid,
    output evt_id,
    output leak_en,
    output fire_en,
    output step_idx,
    output overrun
  );

  // Core / spike source side
  modport slave (
    output spike_in,
    output evt_ready,
    input  evt_valid,
    input  evt_id,
    input  leak_en,
    input  fire_en,
    input  step_idx,
    input  overrun
  );
endinterface

// File: rtl/snn_step_scheduler.sv
// Timestep scheduler: latches input spikes per step, serializes them round-robin
// onto the shared accumulate datapath, then sequences leak and fire.
module snn_step_scheduler #(
  parameter int unsigned N_IN        = 3,
  parameter int unsigned STEP_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  snn_step_scheduler_if.master bus
);
  localparam int unsigned IDW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned CW  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(N_IN - 1);

  localparam logic [1:0] S_COLLECT  = 2'd0;
  localparam logic [1:0] S_DISPATCH = 2'd1;
  localparam logic [1:0] S_LEAK     = 2'd2;
  localparam logic [1:0] S_FIRE     = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0] pending_q, pending_d;
  logic [N_IN-1:0] work_q, work_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [7:0]      step_q, step_d;

  logic            boundary_c;
  logic            evt_valid_c;
  logic [IDW-1:0]  pick_id;
  logic            pick_found;
  int unsigned     pos;

  assign boundary_c  = (cnt_q == CNT_LAST);
  assign evt_valid_c = (state_q == S_DISPATCH) && (work_q != '0);

  // First set work bit at or above rr, wrapping modulo N_IN
  always_comb begin
    pick_id    = '0;
    pick_found = 1'b0;
    pos        = 0;
    for (int i = 0; i < int'(N_IN); i++) begin
      pos = int'(rr_q) + i;
      if (pos >= N_IN) pos = pos - N_IN;
      if (!pick_found && work_q[IDW'(pos)]) begin
        pick_found = 1'b1;
        pick_id    = IDW'(pos);
      end
    end
  end

  // Next-state and datapath update; spikes accumulate in every state
  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    rr_d      = rr_q;
    step_d    = step_q;
    pending_d = pending_q | bus.spike_in;
    cnt_d     = boundary_c ? '0 : cnt_q + CW'(1);
    case (state_q)
      S_COLLECT: begin
        if (boundary_c) begin
          work_d    = pending_q;
          pending_d = bus.spike_in;
          state_d   = S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        if (work_q == '0) begin
          state_d = S_LEAK;
        end else if (bus.evt_ready) begin
          work_d[pick_id] = 1'b0;
          rr_d = (pick_id == ID_LAST) ? '0 : pick_id + IDW'(1);
          if (work_d == '0) state_d = S_LEAK;
        end
      end
      S_LEAK: begin
        state_d = S_FIRE;
      end
      S_FIRE: begin
        step_d  = step_q + 8'd1;
        state_d = S_COLLECT;
      end
      default: begin
        state_d = S_COLLECT;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_COLLECT;
      cnt_q     <= '0;
      pending_q <= '0;
      work_q    <= '0;
      rr_q      <= '0;
      step_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      work_q    <= work_d;
      rr_q      <= rr_d;
      step_q    <= step_d;
    end
  end

  // Outputs decode registered state only, never evt_ready
  assign bus.evt_valid = evt_valid_c;
  assign bus.evt_id    = evt_valid_c ? pick_id : '0;
  assign bus.leak_en   = (state_q == S_LEAK);
  assign bus.fire_en   = (state_q == S_FIRE);
  assign bus.step_idx  = step_q;
  assign bus.overrun   = boundary_c && (state_q != S_COLLECT);

endmodule

// File: tb/tb_snn_step_scheduler.sv
// Scoreboard bench for snn_step_scheduler (N_IN=3, STEP_CYCLES=16).
module tb_snn_step_scheduler;
  localparam int K_EVT  = 0;
  localparam int K_LEAK = 1;
  localparam int K_FIRE = 2;
  localparam int K_OVR  = 3;

  typedef struct {
    int kind;
    int id;
    int cyc;
    int step;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_q = 1'b1;
  int   cyc = 0;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  logic       prev_stall = 1'b0;
  logic [1:0] prev_id = 2'd0;

  snn_step_scheduler_if #(.N_IN(3)) bus ();

  snn_step_scheduler #(.N_IN(3), .STEP_CYCLES(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release: cycle k has the step counter at k mod 16
  always @(posedge clk) begin
    rst_q <= rst;
    cyc   <= rst ? 0 : cyc + 1;
  end

  function automatic int outs();
    return int'({bus.evt_valid, bus.evt_id, bus.leak_en, bus.fire_en, bus.overrun, bus.step_idx});
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input int k, input int id, input int c, input int s);
    exp_t e;
    e.kind = k; e.id = id; e.cyc = c; e.step = s;
    sb.push_back(e);
  endtask

  task automatic observe(input int k, input int id);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      $display("FAIL sb_unexpected: got kind=%0d id=%0d cyc=%0d step=%0d, expected no output",
               k, id, cyc, bus.step_idx);
    end else begin
      e = sb.pop_front();
      if (e.kind == k && e.id == id && e.cyc == cyc && e.step == int'(bus.step_idx)) passes++;
      else $display("FAIL sb_compare: got kind=%0d id=%0d cyc=%0d step=%0d, expected kind=%0d id=%0d cyc=%0d step=%0d",
                    k, id, cyc, bus.step_idx, e.kind, e.id, e.cyc, e.step);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output
  always @(negedge clk) begin
    if (rst || rst_q) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) check("evt_hold", int'({bus.evt_valid, bus.evt_id}), int'({1'b1, prev_id}));
      prev_stall <= bus.evt_valid && !bus.evt_ready;
      prev_id    <= bus.evt_id;
      if (bus.overrun) observe(K_OVR, 0);
      if (bus.evt_valid && bus.evt_ready) observe(K_EVT, int'(bus.evt_id));
      if (bus.leak_en) observe(K_LEAK, 0);
      if (bus.fire_en) observe(K_FIRE, 0);
    end
  end

  task automatic at_cycle(input int c);
    int n;
    n = 0;
    while (cyc != c && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (cyc != c) check("wait_cycle", cyc, c);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.spike_in  = 3'b111;
    bus.evt_ready = 1'b1;

    // Reset held two cycles with all spikes asserted
    @(posedge clk); @(negedge clk);
    check("reset_outs_1", outs(), 0);
    @(posedge clk); @(negedge clk);
    check("reset_outs_2", outs(), 0);
    rst = 1'b0;
    bus.spike_in = 3'b000;
    push(K_LEAK, 0, 17, 0);
    push(K_FIRE, 0, 18, 0);

    // Basic dispatch: sources 0 and 2, boundary at 31
    at_cycle(20);
    check("step_after_first", int'(bus.step_idx), 1);
    push(K_EVT, 0, 32, 1); push(K_EVT, 2, 33, 1);
    push(K_LEAK, 0, 34, 1); push(K_FIRE, 0, 35, 1);
    bus.spike_in = 3'b101;
    at_cycle(21); bus.spike_in = 3'b000;

    // Back-pressure: ready low for cycles 48..52, boundary at 47
    at_cycle(40);
    push(K_EVT, 0, 53, 2); push(K_EVT, 2, 54, 2);
    push(K_LEAK, 0, 55, 2); push(K_FIRE, 0, 56, 2);
    bus.spike_in = 3'b101;
    at_cycle(41); bus.spike_in = 3'b000;
    at_cycle(48); bus.evt_ready = 1'b0;
    @(negedge clk);
    check("bp_offer", int'({bus.evt_valid, bus.evt_id}), 3'b100);
    at_cycle(53); bus.evt_ready = 1'b1;

    // Round-robin: source 1 alone, then all three starting from rr=2
    at_cycle(58);
    push(K_EVT, 1, 64, 3); push(K_LEAK, 0, 65, 3); push(K_FIRE, 0, 66, 3);
    bus.spike_in = 3'b010;
    at_cycle(59); bus.spike_in = 3'b000;
    at_cycle(70);
    push(K_EVT, 2, 80, 4); push(K_EVT, 0, 81, 4); push(K_EVT, 1, 82, 4);
    push(K_LEAK, 0, 83, 4); push(K_FIRE, 0, 84, 4);
    bus.spike_in = 3'b111;
    at_cycle(71); bus.spike_in = 3'b000;

    // Boundary collision: source 1 arrives in boundary cycle 95, served next step
    at_cycle(88);
    push(K_EVT, 2, 96, 5); push(K_EVT, 0, 97, 5);
    push(K_LEAK, 0, 98, 5); push(K_FIRE, 0, 99, 5);
    push(K_EVT, 1, 112, 6); push(K_LEAK, 0, 113, 6); push(K_FIRE, 0, 114, 6);
    bus.spike_in = 3'b101;
    at_cycle(89); bus.spike_in = 3'b000;
    at_cycle(95); bus.spike_in = 3'b010;
    at_cycle(96); bus.spike_in = 3'b000;

    // Overrun: ready low 20 cycles, boundary 143 skipped, source 2 carried over
    at_cycle(120);
    push(K_OVR, 0, 143, 7);
    push(K_EVT, 0, 148, 7); push(K_LEAK, 0, 149, 7); push(K_FIRE, 0, 150, 7);
    push(K_EVT, 2, 160, 8); push(K_LEAK, 0, 161, 8); push(K_FIRE, 0, 162, 8);
    bus.spike_in = 3'b001;
    at_cycle(121); bus.spike_in = 3'b000;
    at_cycle(128); bus.evt_ready = 1'b0;
    at_cycle(135); bus.spike_in = 3'b100;
    at_cycle(136); bus.spike_in = 3'b000;
    at_cycle(148); bus.evt_ready = 1'b1;

    // Reset mid-dispatch: events offered from 176, reset in cycle 177
    at_cycle(165); bus.spike_in = 3'b111;
    at_cycle(166); bus.spike_in = 3'b000;
    at_cycle(176); bus.evt_ready = 1'b0;
    @(negedge clk);
    check("mid_offer", int'({bus.evt_valid, bus.evt_id}), 3'b100);
    at_cycle(177);
    check("sb_drained_before_reset", sb.size(), 0);
    rst = 1'b1;
    bus.spike_in = 3'b111;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.spike_in  = 3'b000;
    bus.evt_ready = 1'b1;
    @(negedge clk);
    check("post_reset_outs", outs(), 0);
    push(K_LEAK, 0, 17, 0);
    push(K_FIRE, 0, 18, 0);
    at_cycle(25);
    check("step_after_reset", int'(bus.step_idx), 1);
    check("sb_final_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
